// File: rtl/clk_div_monitor_if.sv
// clk_div_monitor_if -- signal bundle between a clock-divider source and
// clk_div_monitor.
//   clk_div_2/4/6 : divider outputs, sampled as data on the monitor clock
//   en            : checking enable
//   clear_err     : synchronous clear pulse
//   lock          : all channels verified
//   err_flags     : sticky per-channel errors ([0]=div2, [1]=div4, [2]=div6)
//   err_cnt       : saturating count of error cycles
// master drives the dividers and controls; slave is the monitor.
interface clk_div_monitor_if;
    logic       clk_div_2;
    logic       clk_div_4;
    logic       clk_div_6;
    logic       en;
    logic       clear_err;
    logic       lock;
    logic [2:0] err_flags;
    logic [7:0] err_cnt;

    modport master (
        output clk_div_2, clk_div_4, clk_div_6, en, clear_err,
        input  lock, err_flags, err_cnt
    );

    modport slave (
        input  clk_div_2, clk_div_4, clk_div_6, en, clear_err,
        output lock, err_flags, err_cnt
    );
endinterface

// File: rtl/clk_div_monitor.sv
// clk_div_monitor -- checks three divided clocks, treated as data sampled on
// clk, against their expected half-periods (HALF2/HALF4/HALF6 clk cycles).
// Ports:
//   clk   : the single clock
//   reset : asynchronous, active-high reset
//   bus   : clk_div_monitor_if.slave (divider inputs, en, clear_err,
//           lock, err_flags, err_cnt)
// Each channel counts cycles since its last level change. A change that
// arrives with the wrong count is a period error; reaching the expected
// count without a change is a stall error. LOCK_RUNS consecutive good
// half-periods on every channel with no sticky error raises lock.
module clk_div_monitor #(
    parameter int unsigned HALF2     = 1,
    parameter int unsigned HALF4     = 2,
    parameter int unsigned HALF6     = 6,
    parameter int unsigned LOCK_RUNS = 4
) (
    input logic              clk,
    input logic              reset,
    clk_div_monitor_if.slave bus
);
    localparam int unsigned GW = (LOCK_RUNS == 0) ? 1 : $clog2(LOCK_RUNS + 1);
    localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_RUNS);
    localparam logic [3:0] HALF_V [3] = '{4'(HALF2), 4'(HALF4), 4'(HALF6)};

    logic [2:0]    x;
    logic [2:0]    prev_q;
    logic [2:0]    armed_q, armed_d;
    logic [3:0]    run_q  [3];
    logic [3:0]    run_d  [3];
    logic [GW-1:0] good_q [3];
    logic [GW-1:0] good_d [3];
    logic          lock_q, lock_d;
    logic [2:0]    flags_q, flags_d;
    logic [7:0]    cnt_q, cnt_d;

    logic [2:0]    edge_w;
    logic [2:0]    hit_w;
    logic [2:0]    err_w;
    logic          all_good;

    assign x = {bus.clk_div_6, bus.clk_div_4, bus.clk_div_2};

    always_comb begin
        edge_w   = x ^ prev_q;
        hit_w    = '0;
        err_w    = '0;
        armed_d  = armed_q;
        all_good = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            hit_w[c]  = (run_q[c] == HALF_V[c]);
            run_d[c]  = edge_w[c] ? 4'd1
                      : ((run_q[c] == 4'hF) ? 4'hF : run_q[c] + 4'd1);
            good_d[c] = good_q[c];
            all_good  = all_good & (good_q[c] == GOOD_MAX);
            if (bus.clear_err || !bus.en) begin
                armed_d[c] = 1'b0;
                good_d[c]  = '0;
            end else begin
                if (edge_w[c]) armed_d[c] = 1'b1;
                if (armed_q[c]) begin
                    // Edge without the expected count (period) or the
                    // expected count without an edge (stall).
                    err_w[c] = edge_w[c] ^ hit_w[c];
                    if (err_w[c])
                        good_d[c] = '0;
                    else if (edge_w[c] && good_q[c] != GOOD_MAX)
                        good_d[c] = good_q[c] + 1'b1;
                end
            end
        end

        if (bus.clear_err) begin
            flags_d = '0;
            cnt_d   = '0;
        end else begin
            flags_d = flags_q | err_w;
            cnt_d   = (|err_w && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
        end

        lock_d = !bus.clear_err && bus.en && all_good && (flags_q == 3'b000);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= '0;
            armed_q <= '0;
            lock_q  <= 1'b0;
            flags_q <= '0;
            cnt_q   <= '0;
            for (int unsigned c = 0; c < 3; c++) begin
                run_q[c]  <= '0;
                good_q[c] <= '0;
            end
        end else begin
            prev_q  <= x;
            armed_q <= armed_d;
            lock_q  <= lock_d;
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            for (int unsigned c = 0; c < 3; c++) begin
                run_q[c]  <= run_d[c];
                good_q[c] <= good_d[c];
            end
        end
    end

    assign bus.lock      = lock_q;
    assign bus.err_flags = flags_q;
    assign bus.err_cnt   = cnt_q;
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor -- directed bench for clk_div_monitor with default
// parameters (HALF2=1, HALF4=2, HALF6=6, LOCK_RUNS=4).
// A divider generator toggles each channel every half[c] cycles; n counts
// posedges since reset release, so sample index n-1 is the last one the
// DUT consumed. Expected outputs are hand-derived constants.
module tb_clk_div_monitor;
    logic clk = 1'b0;
    logic reset;

    clk_div_monitor_if bus();

    clk_div_monitor #(
        .HALF2(1), .HALF4(2), .HALF6(6), .LOCK_RUNS(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int n      = 0;

    logic [2:0] lvl, frc, frc_val;
    int         cnt  [3];
    int         half [3];

    typedef struct {
        logic en;
        logic clr;
        int   upto;
        bit   hold;
        int   lock;
        int   flags;
        int   cnt;
    } vec_t;

    vec_t tbl [8];

    task automatic drive();
        logic [2:0] v;
        v = (frc & frc_val) | (~frc & lvl);
        bus.clk_div_2 = v[0];
        bus.clk_div_4 = v[1];
        bus.clk_div_6 = v[2];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        n++;
        for (int c = 0; c < 3; c++) begin
            cnt[c]++;
            if (cnt[c] >= half[c]) begin
                lvl[c] = ~lvl[c];
                cnt[c] = 0;
            end
        end
        drive();
    endtask

    task automatic run_to(input int target);
        while (n < target) cyc();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int l, input int f, input int c);
        chk({tag, ".lock"},  int'(bus.lock),      l);
        chk({tag, ".flags"}, int'(bus.err_flags), f);
        chk({tag, ".cnt"},   int'(bus.err_cnt),   c);
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.en        = 1'b1;
        bus.clear_err = 1'b0;
        lvl           = '0;
        frc           = '0;
        frc_val       = '0;
        half[0] = 1; half[1] = 2; half[2] = 6;
        for (int c = 0; c < 3; c++) cnt[c] = 0;
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        n     = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int bad;

        //         en    clr   upto hold lock flags cnt
        tbl[0] = '{1'b1, 1'b0,   1, 0,   0,   0,    0};
        tbl[1] = '{1'b1, 1'b0,  31, 0,   0,   0,    0};
        tbl[2] = '{1'b1, 1'b0,  32, 0,   1,   0,    0};
        tbl[3] = '{1'b1, 1'b0,  60, 1,   1,   0,    0};
        tbl[4] = '{1'b0, 1'b0,  61, 0,   0,   0,    0};
        tbl[5] = '{1'b1, 1'b0,  91, 0,   0,   0,    0};
        tbl[6] = '{1'b1, 1'b0,  92, 0,   1,   0,    0};
        tbl[7] = '{1'b1, 1'b0, 120, 1,   1,   0,    0};

        // Ideal dividers: lock, hold, drop on en=0, relock.
        do_reset();
        chk_out("reset", 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            bad = 0;
            bus.en        = tbl[i].en;
            bus.clear_err = tbl[i].clr;
            while (n < tbl[i].upto) begin
                cyc();
                if (tbl[i].hold && n < tbl[i].upto && int'(bus.lock) != tbl[i].lock)
                    bad++;
            end
            chk_out($sformatf("vec%0d", i), tbl[i].lock, tbl[i].flags, tbl[i].cnt);
            if (tbl[i].hold) chk($sformatf("vec%0d.held", i), bad, 0);
        end

        // div4 half-period stretched to 3: stall, then period error.
        do_reset();
        run_to(40);
        chk_out("B.pre", 1, 0, 0);
        half[1] = 3;
        run_to(43);
        half[1] = 2;
        chk_out("B.stall", 1, 3'b010, 1);
        run_to(44);
        chk_out("B.period", 0, 3'b010, 2);
        bad = 0;
        while (n < 100) begin
            cyc();
            if (bus.lock !== 1'b0) bad++;
        end
        chk("B.nolock", bad, 0);
        bus.clear_err = 1'b1;
        run_to(101);
        bus.clear_err = 1'b0;
        chk_out("B.clear", 0, 0, 0);

        // div6 half-period shortened to 5, then clear and relock.
        do_reset();
        run_to(36);
        half[2] = 5;
        run_to(41);
        half[2] = 6;
        run_to(42);
        chk_out("C.err", 1, 3'b100, 1);
        run_to(43);
        chk_out("C.unlock", 0, 3'b100, 1);
        run_to(50);
        bus.clear_err = 1'b1;
        run_to(51);
        bus.clear_err = 1'b0;
        chk_out("C.clear", 0, 0, 0);
        run_to(78);
        chk_out("C.prelock", 0, 0, 0);
        run_to(79);
        chk_out("C.relock", 1, 0, 0);

        // All inputs frozen low after a common edge at sample 36.
        do_reset();
        run_to(37);
        frc     = 3'b111;
        frc_val = 3'b000;
        drive();
        run_to(38);
        chk_out("D.s2", 1, 3'b001, 1);
        run_to(39);
        chk_out("D.s4", 0, 3'b011, 2);
        run_to(42);
        chk_out("D.mid", 0, 3'b011, 2);
        run_to(43);
        chk_out("D.s6", 0, 3'b111, 3);
        run_to(60);
        chk_out("D.settled", 0, 3'b111, 3);

        // Two more div2 errors (period then stall) to reach err_cnt=5,
        // then asynchronous reset between clock edges.
        frc_val[0] = 1'b1;
        drive();
        run_to(62);
        chk_out("F.cnt5", 0, 3'b111, 5);
        run_to(63);
        chk_out("F.cnt5b", 0, 3'b111, 5);
        #2;
        reset = 1'b1;
        #1;
        chk_out("F.async", 0, 0, 0);
        do_reset();
        run_to(40);
        chk_out("F.restart", 1, 0, 0);

        // clear_err in the same cycle as a div2 stall error.
        do_reset();
        run_to(40);
        half[0] = 2;
        run_to(41);
        half[0] = 1;
        bus.clear_err = 1'b1;
        run_to(42);
        bus.clear_err = 1'b0;
        chk_out("E.clr", 0, 0, 0);
        run_to(43);
        chk_out("E.after", 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clk_div_monitor.md
CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

Interface
REQ-001 SHALL have parameter HALF2, default 1, meaning expected half-period of clk_div_2 in clk cycles.
REQ-002 SHALL have parameter HALF4, default 2, meaning expected half-period of clk_div_4 in clk cycles.
REQ-003 SHALL have parameter HALF6, default 6, meaning expected half-period of clk_div_6 in clk cycles.
REQ-004 SHALL have parameter LOCK_RUNS, default 4, meaning consecutive good half-periods per channel required for lock.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have ports clk_div_2, clk_div_4 and clk_div_6, each input, 1 bit: divider outputs, sampled as data on posedge clk.
REQ-008 SHALL have port en, input, 1 bit: checking enable.
REQ-009 SHALL have port clear_err, input, 1 bit: synchronous clear pulse.
REQ-010 SHALL have port lock, output, 1 bit: all channels verified.
REQ-011 SHALL have port err_flags, output, 3 bits: sticky per-channel errors ([0]=div2, [1]=div4, [2]=div6).
REQ-012 SHALL have port err_cnt, output, 8 bits: saturating count of error cycles.

Function (per channel x, all registered on posedge clk)
REQ-013 SHALL register prev_x <= x every cycle regardless of en; edge_x = (x != prev_x).
REQ-014 SHALL keep run_x, 4 bits: on edge_x load 1, else increment, saturating at 15.
REQ-015 SHALL set armed_x on the first edge_x while en=1; before armed_x, no errors or good counts occur for x (first run is partial).
REQ-016 SHALL flag a period error when armed_x, edge_x and run_x != HALFx.
REQ-017 SHALL flag a stall error when armed_x, !edge_x and run_x == HALFx (that cycle, not later).
REQ-018 SHALL, on armed_x and edge_x with run_x == HALFx, increment good_x, saturating at LOCK_RUNS.
REQ-019 SHALL, on any error on x, set err_flags[x] (sticky) and zero good_x in the same cycle; armed_x stays set.
REQ-020 SHALL increment err_cnt by exactly 1 in any cycle with one or more channel errors, saturating at 255.
REQ-021 SHALL register lock as 1 in the cycle after good_2 == good_4 == good_6 == LOCK_RUNS and err_flags == 0; otherwise 0.
REQ-022 SHALL, when en=0, clear armed_x, good_x and lock, flag no errors, and hold err_flags and err_cnt.
REQ-023 SHALL, on clear_err=1, zero err_flags, err_cnt, good_x, armed_x and lock next cycle; clear_err wins over a simultaneous error (that error is dropped).
REQ-024 SHALL allow simultaneous errors on several channels in one cycle, each setting its own flag.

Reset
REQ-025 SHALL, while reset=1, asynchronously force prev_x=0, run_x=0, armed_x=0, good_x=0, lock=0, err_flags=3'b000 and err_cnt=0.
REQ-026 SHALL, on reset deassertion mid-operation, restart from the all-zero state without any error caused by pre-reset history.

Verification
REQ-027 SHALL cover: reset, en=1, ideal divider (div2 toggles every cycle, div4 every 2, div6 every 6) -> err_flags=000, err_cnt=0, lock=1 within 6*(LOCK_RUNS+1)+2 cycles and held.
REQ-028 SHALL cover: locked, then one div4 half-period stretched to 3 -> stall error that cycle, err_flags=3'b010, err_cnt=1, lock=0 next cycle, and lock never returns until clear_err.
REQ-029 SHALL cover: locked, then one div6 half-period shortened to 5 -> err_flags=3'b100, err_cnt=1; after clear_err and 4 good runs, lock=1.
REQ-030 SHALL cover: all three inputs frozen at 0 after lock -> div2, div4 and div6 stall errors in the cycles where run_x reaches HALFx, err_flags=3'b111, and err_cnt increments once per error cycle.
REQ-031 SHALL cover: clear_err asserted in the same cycle as a div2 error -> err_flags=000, err_cnt=0 next cycle.
REQ-032 SHALL cover: reset asserted mid-run with err_cnt=5 -> all outputs 0 immediately, without waiting for a clk edge.
